seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Bus-mapped, N-digit multiplexed 7-segment display controller; CPU-side registers, scan-side drive.
//  Sits on the cpu data bus (address/dout/din/read) beside sram; replaces hard-wired digit muxing in board tops.
//  Adds a programmable scan rate, per-digit decimal points, per-digit blanking and blinking, and per-digit raw-segment mode.
//  Adds dead-time between digits to suppress ghosting.
// PARAMETERS
//  NDIGITS      4      digits scanned, 1..8
//  PRESC_RESET  16'd520 reset value of scan prescaler (clk cycles per digit - 1)
//  DEAD_CYCLES  2      clk cycles all digits off at each digit change, 0..15
//  BLINK_SHIFT  8      blink phase toggles every 2^BLINK_SHIFT digit ticks
//  SEG_ACT_LOW  1      1: seg outputs active-low
//  DIG_ACT_LOW  0      1: dig outputs active-low
// PORTS
//  clk    in   1        single clock
//  rst    in   1        synchronous, active-high reset
//  cs     in   1        chip select from top-level address decode
//  read   in   1        1 = read cycle, 0 = write cycle (cpu convention)
//  addr   in   4        register offset
//  din    in   8        write data (cpu dout)
//  dout   out  8        read data (to cpu din mux)
//  seg    out  8        {dp,g,f,e,d,c,b,a}
//  dig    out  NDIGITS  one-hot digit enable
// BEHAVIOUR
//  Register map (write when cs & ~read at posedge clk):
//   0x0-0x7 DIGn: bits[3:0] hex nibble, or bits[6:0] raw {g..a} when RAW[n]=1; n>=NDIGITS ignored
//   0x8 DP  0x9 BLANK  0xA BLINK  0xB RAW : per-digit masks, bit n = digit n
//   0xC PRE_LO  0xD PRE_HI : prescaler; write to either byte clears prescaler counter
//   0xE CTRL: bit0 EN (0: all dig inactive, scan frozen), bit1 BLINK_EN
//   0xF ID: read-only {4'hA, NDIGITS-1}; writes ignored
//  Reads: dout registered; updated at posedge when cs & read, value valid next cycle; otherwise holds.
//   Unused bits read 0; DIGn with n>=NDIGITS read 8'hFF.
//  Reset: all regs 0 except PRE=PRESC_RESET, CTRL=8'h01; dout=8'hFF; scan idx=0; presc cnt=0;
//   dead cnt=0; blink phase=0; seg/dig driven inactive (polarity per params) in the reset cycle and the cycle after.
//  Scan FSM: SHOW -> DEAD -> SHOW.
//   SHOW: presc cnt counts 0..PRE; at cnt==PRE: cnt<=0, idx<=idx+1 (wrap NDIGITS-1->0), tick=1, enter DEAD.
//   DEAD: all dig inactive for DEAD_CYCLES clks, then SHOW; DEAD_CYCLES=0 skips DEAD.
//   PRE=0: tick every SHOW cycle.
//   EN=0: FSM holds state and counters, dig inactive, seg inactive; EN 0->1 resumes at same idx.
//  Blink: blink cnt (BLINK_SHIFT bits) increments on tick; phase toggles on its wrap.
//   Digit blanked if BLANK[idx] | (BLINK_EN & BLINK[idx] & phase).
//  Segment data: RAW[idx] ? DIGidx[6:0] : hexdecode(DIGidx[3:0]); dp = DP[idx]; blanked -> all seg and dig inactive.
//  seg/dig are registered: output reflects idx and registers as of the previous cycle (1-cycle latency).
//   A register write is visible on seg at most 2 cycles later.
//  Write to PRE during DEAD: dead cnt unaffected; new PRE used from the next SHOW.
//  Simultaneous write and tick: tick uses the old PRE; counter clear from the write wins.
// STRUCTURE
//  Package seg_scan_pkg: register offset localparams, CTRL bit indices, FSM state enum {SHOW, DEAD}.
//  Sub-module seg_hex_decode: combinational 4-bit -> 7-bit {g..a} active-high, 0-F full set.
//   Polarity is applied in the top only.
// TESTING
//  T1 reset, PRE=3, DEAD=2, NDIGITS=4: dig sequence 0001 x4 clk, 0000 x2, 0010 x4, ... wraps to 0001 after 1000.
//  T2 write DIG1=8'h05, RAW=0: while dig=0010, seg=8'b1_0010010 (active-low '5', dp off); set DP=0010 -> seg[7]=0.
//  T3 RAW=0001, DIG0=8'h49: seg[6:0] on digit 0 = ~7'h49; DIG0 read back after 1 cycle = 8'h49.
//  T4 BLINK=0100, BLINK_EN=1, BLINK_SHIFT=2: digit 2 blanked (dig and seg inactive) on alternate groups of 4 ticks.
//   Other digits unaffected.
//  T5 CTRL=0 mid-SHOW: dig=0 next cycle, idx/cnt frozen; CTRL=1: scan resumes at same digit, remaining count intact.
//  T6 rst asserted mid-DEAD: next cycles dig=0, seg inactive, regs at reset values, ID reads 8'hA3, read DIG5 = 8'hFF.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// register offsets, CTRL bit positions and scan FSM state encoding.
package seg_scan_pkg;

   localparam logic [3:0] REG_DP     = 4'h8;
   localparam logic [3:0] REG_BLANK  = 4'h9;
   localparam logic [3:0] REG_BLINK  = 4'hA;
   localparam logic [3:0] REG_RAW    = 4'hB;
   localparam logic [3:0] REG_PRE_LO = 4'hC;
   localparam logic [3:0] REG_PRE_HI = 4'hD;
   localparam logic [3:0] REG_CTRL   = 4'hE;
   localparam logic [3:0] REG_ID     = 4'hF;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_BLINK_EN = 1;

   typedef enum logic {
      SHOW = 1'b0,
      DEAD = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU-side register bus for the segment scan controller.
interface seg_scan_ctrl_if;
   logic       cs;
   logic       read;
   logic [3:0] addr;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output cs, output read, output addr, output din, input dout);
   modport slave  (input cs, input read, input addr, input din, output dout);
endinterface

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg_hex_decode (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h00;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Bus-mapped N-digit multiplexed 7-segment controller with dead-time,
// blanking, blinking and raw-segment mode.
//
//   state | meaning
//   SHOW  | current digit driven, prescaler counting 0..PRE
//   DEAD  | all digits off for DEAD_CYCLES clocks after a digit change
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int          NDIGITS     = 4,
   parameter logic [15:0] PRESC_RESET = 16'd520,
   parameter int          DEAD_CYCLES = 2,
   parameter int          BLINK_SHIFT = 8,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          DIG_ACT_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   seg_scan_ctrl_if.slave      bus,
   output logic [7:0]          seg,
   output logic [NDIGITS-1:0]  dig
);

   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [3:0] DEAD_LAST = (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;
   localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [NDIGITS-1:0] DIG_OFF = DIG_ACT_LOW ? '1 : '0;

   logic [7:0]         dig_reg [NDIGITS];
   logic [NDIGITS-1:0] dp_msk, blank_msk, blink_msk, raw_msk;
   logic [15:0]        pre;
   logic               en, blink_en;

   logic wr, pre_wr;
   logic [7:0] rd_data;

   assign wr     = bus.cs & ~bus.read;
   assign pre_wr = wr & ((bus.addr == REG_PRE_LO) | (bus.addr == REG_PRE_HI));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NDIGITS; i++) dig_reg[i] <= 8'h00;
         dp_msk    <= '0;
         blank_msk <= '0;
         blink_msk <= '0;
         raw_msk   <= '0;
         pre       <= PRESC_RESET;
         en        <= 1'b1;
         blink_en  <= 1'b0;
         bus.dout  <= 8'hFF;
      end else begin
         if (wr) begin
            for (int i = 0; i < NDIGITS; i++)
               if (bus.addr == 4'(i)) dig_reg[i] <= bus.din;
            case (bus.addr)
               REG_DP:     dp_msk    <= bus.din[NDIGITS-1:0];
               REG_BLANK:  blank_msk <= bus.din[NDIGITS-1:0];
               REG_BLINK:  blink_msk <= bus.din[NDIGITS-1:0];
               REG_RAW:    raw_msk   <= bus.din[NDIGITS-1:0];
               REG_PRE_LO: pre[7:0]  <= bus.din;
               REG_PRE_HI: pre[15:8] <= bus.din;
               REG_CTRL: begin
                  en       <= bus.din[CTRL_EN];
                  blink_en <= bus.din[CTRL_BLINK_EN];
               end
               default: ;
            endcase
         end
         if (bus.cs & bus.read) bus.dout <= rd_data;
      end
   end

   // Digit slots beyond NDIGITS read back as all ones.
   always_comb begin
      rd_data = 8'h00;
      if (!bus.addr[3]) begin
         rd_data = 8'hFF;
         for (int i = 0; i < NDIGITS; i++)
            if (bus.addr[2:0] == 3'(i)) rd_data = dig_reg[i];
      end else begin
         case (bus.addr)
            REG_DP:     rd_data = 8'(dp_msk);
            REG_BLANK:  rd_data = 8'(blank_msk);
            REG_BLINK:  rd_data = 8'(blink_msk);
            REG_RAW:    rd_data = 8'(raw_msk);
            REG_PRE_LO: rd_data = pre[7:0];
            REG_PRE_HI: rd_data = pre[15:8];
            REG_CTRL:   rd_data = {6'b0, blink_en, en};
            REG_ID:     rd_data = {4'hA, 4'(NDIGITS - 1)};
            default:    rd_data = 8'h00;
         endcase
      end
   end

   scan_state_t            state;
   logic [IDX_W-1:0]       idx;
   logic [15:0]            presc_cnt;
   logic [3:0]             dead_cnt;
   logic [BLINK_SHIFT-1:0] blink_cnt;
   logic                   blink_ph;

   logic [6:0] hex_seg;
   logic [7:0] seg_act;
   logic       blanked, show;

   seg_hex_decode u_hex (
      .nib (dig_reg[idx][3:0]),
      .seg (hex_seg)
   );

   assign blanked = blank_msk[idx] | (blink_en & blink_msk[idx] & blink_ph);
   assign show    = en & (state == SHOW) & ~blanked;
   assign seg_act = {dp_msk[idx], raw_msk[idx] ? dig_reg[idx][6:0] : hex_seg};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SHOW;
         idx       <= '0;
         presc_cnt <= '0;
         dead_cnt  <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         seg       <= SEG_OFF;
         dig       <= DIG_OFF;
      end else begin
         seg <= show ? (SEG_ACT_LOW ? ~seg_act : seg_act) : SEG_OFF;
         dig <= show ? ((NDIGITS'(1) << idx) ^ DIG_OFF) : DIG_OFF;
         if (en) begin
            case (state)
               SHOW: begin
                  if (presc_cnt == pre) begin
                     presc_cnt <= '0;
                     idx       <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + 1'b1;
                     blink_cnt <= blink_cnt + 1'b1;
                     if (&blink_cnt) blink_ph <= ~blink_ph;
                     dead_cnt  <= '0;
                     state     <= (DEAD_CYCLES == 0) ? SHOW : DEAD;
                  end else begin
                     presc_cnt <= presc_cnt + 16'd1;
                  end
               end
               DEAD: begin
                  if (dead_cnt == DEAD_LAST) begin
                     dead_cnt <= '0;
                     state    <= SHOW;
                  end else begin
                     dead_cnt <= dead_cnt + 4'd1;
                  end
               end
               default: state <= SHOW;
            endcase
         end
         // A prescaler write restarts the digit period even if a tick fired this cycle.
         if (pre_wr) presc_cnt <= '0;
      end
   end

endmodule
